// File: rtl/regfile_pkg.sv
// Shared register-file constants and the register index type used by the
// write-port arbiter and its testbench.
package regfile_pkg;

  localparam int XLEN       = 64;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: scans req starting at ptr, wrapping,
// and grants the first asserted index.
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_grant
);

  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!any_grant && req[idx]) begin
        any_grant  = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin sharing of the single register-file write port among NUM_REQ
// writeback sources. Optional build macro: REGFILE_X0_HARDWIRE_EN (x0 never written).
module regfile_write_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int XLEN       = regfile_pkg::XLEN,
  parameter int REG_ADDR_W = regfile_pkg::REG_ADDR_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*REG_ADDR_W-1:0] req_rd,
  input  logic [NUM_REQ*XLEN-1:0]      req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         RegWrite,
  output logic [REG_ADDR_W-1:0]        RD,
  output logic [XLEN-1:0]              WriteData,
  output logic [31:0]                  pending_mask
);

  import regfile_pkg::*;

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [REG_ADDR_W-1:0] rd_arr   [NUM_REQ];
  logic [XLEN-1:0]       data_arr [NUM_REQ];

  logic [IDX_W-1:0]      rr_ptr_reg;
  logic [IDX_W-1:0]      rr_ptr_next;
  logic                  regwrite_reg;
  logic [REG_ADDR_W-1:0] rd_reg;
  logic [XLEN-1:0]       wdata_reg;

  logic [NUM_REQ-1:0]    grant;
  logic [IDX_W-1:0]      grant_idx;
  logic                  any_grant;
  logic                  transfer;
  logic                  write_en_next;
  logic [NUM_REGS-1:0]   pending_next;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign rd_arr[gi]   = req_rd[gi*REG_ADDR_W +: REG_ADDR_W];
      assign data_arr[gi] = req_data[gi*XLEN +: XLEN];
    end
  endgenerate

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (rr_ptr_reg),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  // No handshake may complete while reset is held.
  assign req_ready = reset ? '0 : grant;
  assign transfer  = any_grant & ~reset;

`ifdef REGFILE_X0_HARDWIRE_EN
  assign write_en_next = transfer && (rd_arr[grant_idx] != '0);
`else
  assign write_en_next = transfer;
`endif

  assign rr_ptr_next = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      regwrite_reg <= 1'b0;
      rd_reg       <= '0;
      wdata_reg    <= '0;
      rr_ptr_reg   <= '0;
    end else begin
      regwrite_reg <= write_en_next;
      if (transfer) begin
        rd_reg     <= rd_arr[grant_idx];
        wdata_reg  <= data_arr[grant_idx];
        rr_ptr_reg <= rr_ptr_next;
      end
    end
  end

  // Registered-but-uncommitted write plus every outstanding request.
  always_comb begin
    pending_next = '0;
    if (regwrite_reg) begin
      pending_next[rd_reg] = 1'b1;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i]) begin
        pending_next[rd_arr[i]] = 1'b1;
      end
    end
`ifdef REGFILE_X0_HARDWIRE_EN
    pending_next[0] = 1'b0;
`endif
  end

  assign pending_mask = pending_next;
  assign RegWrite     = regwrite_reg;
  assign RD           = rd_reg;
  assign WriteData    = wdata_reg;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomised scoreboard bench for regfile_write_arbiter with directed scenarios;
// a reference model predicts grants, pending masks and the write stream.
module tb_regfile_write_arbiter;

  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 64;
`ifdef REGFILE_X0_HARDWIRE_EN
  localparam bit X0_HW = 1'b1;
`else
  localparam bit X0_HW = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [N-1:0]      req_valid = '0;
  logic [N*AW-1:0]   req_rd = '0;
  logic [N*DW-1:0]   req_data = '0;
  logic [N-1:0]      req_ready;
  logic              RegWrite;
  logic [AW-1:0]     RD;
  logic [DW-1:0]     WriteData;
  logic [31:0]       pending_mask;

  regfile_write_arbiter #(.NUM_REQ(N), .XLEN(DW), .REG_ADDR_W(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_rd       (req_rd),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .RegWrite     (RegWrite),
    .RD           (RD),
    .WriteData    (WriteData),
    .pending_mask (pending_mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } wr_t;

  wr_t  exp_q[$];
  wr_t  mon_e;
  int   total = 0;
  int   bad = 0;
  logic tb_init = 1'b1;

  // Reference model state: round-robin start point and the write that is
  // registered (presented to the register file) during the current cycle.
  int            m_ptr = 0;
  bit            m_we = 1'b0;
  logic [AW-1:0] m_rd = '0;

  // External register file as seen through the write port.
  logic [DW-1:0] rf [32];
  logic [31:0]   rf_written;

  always @(posedge clk) begin
    if (tb_init) begin
      rf_written <= '0;
    end else if (RegWrite && !reset) begin
      rf[RD]         <= WriteData;
      rf_written[RD] <= 1'b1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] rd, input logic [DW-1:0] data);
    req_valid[i]          = 1'b1;
    req_rd[i*AW +: AW]    = rd;
    req_data[i*DW +: DW]  = data;
  endtask

  // One clock cycle: predict and check combinational outputs, queue the
  // expected write, advance the model, retire the granted requester.
  task automatic step(output int w);
    logic [N-1:0]  exp_ready;
    logic [31:0]   exp_mask;
    logic [AW-1:0] rd_i;
    int            i;
    #1;
    w = -1;
    if (!reset) begin
      for (int d = 0; d < N; d++) begin
        i = (m_ptr + d) % N;
        if (w < 0 && req_valid[i]) w = i;
      end
    end
    exp_ready = '0;
    if (w >= 0) exp_ready[w] = 1'b1;
    chk("ready", 64'(req_ready), 64'(exp_ready));

    exp_mask = '0;
    if (m_we) exp_mask[m_rd] = 1'b1;
    for (int k = 0; k < N; k++) begin
      rd_i = req_rd[k*AW +: AW];
      if (req_valid[k]) exp_mask[rd_i] = 1'b1;
    end
    if (X0_HW) exp_mask[0] = 1'b0;
    chk("pending_mask", 64'(pending_mask), 64'(exp_mask));

    if (reset) begin
      m_ptr = 0;
      m_we  = 1'b0;
    end else if (w >= 0) begin
      m_ptr = (w + 1) % N;
      m_rd  = req_rd[w*AW +: AW];
      m_we  = !(X0_HW && m_rd == '0);
      if (m_we) exp_q.push_back('{rd: m_rd, data: req_data[w*DW +: DW]});
    end else begin
      m_we = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    if (w >= 0) req_valid[w] = 1'b0;
  endtask

  // Monitor: every presented write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!tb_init && RegWrite === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL mon_unexpected_write actual RD=%0d data=%0h required=no write", RD, WriteData);
      end else begin
        mon_e = exp_q.pop_front();
        chk("mon_rd", 64'(RD), 64'(mon_e.rd));
        chk("mon_data", WriteData, mon_e.data);
      end
    end
  end

  initial begin
    int w;
    // Reset with a request held: no handshake may happen.
    repeat (2) @(negedge clk);
    set_req(0, 5'd4, 64'h1);
    step(w);
    req_valid = '0;
    chk("rst_regwrite", 64'(RegWrite), 64'd0);
    chk("rst_rd", 64'(RD), 64'd0);
    chk("rst_wdata", WriteData, 64'd0);
    tb_init = 1'b0;
    reset   = 1'b0;

    // Idle after reset.
    for (int k = 0; k < 5; k++) begin
      step(w);
      chk("idle_regwrite", 64'(RegWrite), 64'd0);
      chk("idle_wdata", WriteData, 64'd0);
    end

    // Single request.
    set_req(0, 5'd7, 64'hDEAD_BEEF);
    step(w);
    chk("single_winner", 64'(w), 64'd0);
    chk("single_regwrite", 64'(RegWrite), 64'd1);
    chk("single_rd", 64'(RD), 64'd7);
    chk("single_wdata", WriteData, 64'hDEAD_BEEF);
    chk("single_pending7", 64'(pending_mask[7]), 64'd1);
    step(w);
    chk("single_done", 64'(RegWrite), 64'd0);

    // Three requesters continuously valid: six back-to-back writes.
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i]) set_req(i, AW'(i + 1), 64'(100 + k * 10 + i));
      end
      step(w);
      chk("burst_regwrite", 64'(RegWrite), 64'd1);
    end
    req_valid = '0;
    step(w);

    // Same destination from two requesters, pointer at 1.
    set_req(1, 5'd5, 64'h11);
    set_req(2, 5'd5, 64'h22);
    step(w);
    chk("same_rd_first", 64'(w), 64'd1);
    step(w);
    chk("same_rd_second", 64'(w), 64'd2);
    step(w);
    chk("rf5_final", rf[5], 64'h22);

    // Reset in the cycle after a grant drops the registered write.
    set_req(0, 5'd9, 64'hABC);
    step(w);
    chk("rst_grant_regwrite", 64'(RegWrite), 64'd1);
    reset = 1'b1;
    step(w);
    chk("rst_drop_regwrite", 64'(RegWrite), 64'd0);
    reset = 1'b0;
    chk("rst_drop_rf9", 64'(rf_written[9]), 64'd0);

    // Write to register 0.
    set_req(0, 5'd0, 64'h55);
    step(w);
    chk("x0_winner", 64'(w), 64'd0);
    chk("x0_regwrite", 64'(RegWrite), X0_HW ? 64'd0 : 64'd1);
    if (!X0_HW) chk("x0_rd", 64'(RD), 64'd0);
    step(w);

    // Randomised traffic obeying the hold-until-ready rule.
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
          set_req(i, AW'($urandom_range(0, 31)), {$urandom, $urandom});
        end
      end
      step(w);
    end

    // Drain with a bounded cycle budget.
    for (int k = 0; k < 20 && req_valid != '0; k++) step(w);
    chk("drain_valid_clear", 64'(req_valid), 64'd0);
    step(w);
    step(w);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
